// File: rtl/pack_to_serial_gen_if.sv
// Frame-in / byte-out handshake bundle for pack_to_serial_gen.
// master: the serialiser side. slave: the buffer/sink side.
interface pack_to_serial_gen_if #(
  parameter int FRAME_BYTES = 16
);
  logic [8*FRAME_BYTES-1:0] Frame;
  logic                     FrameReady;
  logic                     FrameNext;
  logic                     ForceSync;
  logic                     DataNext;
  logic [7:0]               DataVal;
  logic                     DataReady;
  logic                     Busy;

  modport master (
    input  Frame, FrameReady, ForceSync, DataNext,
    output FrameNext, DataVal, DataReady, Busy
  );

  modport slave (
    output Frame, FrameReady, ForceSync, DataNext,
    input  FrameNext, DataVal, DataReady, Busy
  );
endinterface

// File: rtl/pack_to_serial_gen.sv
// Frame-to-byte serialiser for the trace output path. Accepts whole frames,
// emits one byte per DataNext request, and prefixes a sync sequence
// (SYNC_BYTES-1 x 0xFF then 0x7F) periodically, after reset, and on demand.
module pack_to_serial_gen #(
  parameter int FRAME_BYTES   = 16,
  parameter int SYNC_INTERVAL = 15,
  parameter int SYNC_BYTES    = 4,
  parameter bit SYNC_ENABLE   = 1'b1,
  parameter bit LSB_FIRST     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  pack_to_serial_gen_if.master bus
);

  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam int MAX_LEN = (FRAME_BYTES > SYNC_BYTES) ? FRAME_BYTES : SYNC_BYTES;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] FRAME_CNT   = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] SYNC_CNT    = CNT_W'(SYNC_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       SYNC_RELOAD = 8'(SYNC_INTERVAL);

  // One-hot state encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SYNC  = 3'b010,
    FRAME = 3'b100
  } stateT;

  stateT              state;
  logic [FRAME_W-1:0] shiftReg;
  logic [CNT_W-1:0]   byteCnt;
  logic [7:0]         syncCountdown;
  logic               syncPending;

  logic               needSync;
  logic [7:0]         nextByte;
  logic [FRAME_W-1:0] shiftedReg;

  // Sync decision for the frame being accepted, and the next frame byte in
  // the configured byte order together with the register after removing it.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here the
    // defaults below); a path that leaves one unassigned infers a latch.
    needSync   = 1'b0;
    nextByte   = shiftReg[7:0];
    shiftedReg = shiftReg >> 8;
    if (SYNC_ENABLE && (syncCountdown == 8'd0 || syncPending)) begin
      needSync = 1'b1;
    end
    if (!LSB_FIRST) begin
      nextByte   = shiftReg[FRAME_W-1 -: 8];
      shiftedReg = shiftReg << 8;
    end
  end

  // Frame shift register: load on acceptance, shift out one byte per request.
  always_ff @(posedge clk) begin
    // NOTE: this data register has no reset; it is always loaded before any
    // of its bytes are emitted, so resetting it would only add logic.
    if (state == IDLE && bus.FrameReady) begin
      shiftReg <= bus.Frame;
    end else if (state == FRAME && bus.DataNext) begin
      shiftReg <= shiftedReg;
    end
  end

  // Control FSM with registered strobes, byte counter, sync scheduling.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    if (!rst) begin
      state         <= IDLE;
      byteCnt       <= '0;
      syncCountdown <= 8'd0;
      syncPending   <= 1'b0;
      bus.FrameNext <= 1'b0;
      bus.DataReady <= 1'b0;
      bus.DataVal   <= 8'h00;
      bus.Busy      <= 1'b0;
    end else begin
      bus.FrameNext <= 1'b0;
      bus.DataReady <= 1'b0;
      // A later assignment on the edge that enters SYNC overrides this, so a
      // request arriving on that same edge is consumed by the sync.
      if (SYNC_ENABLE && bus.ForceSync) begin
        syncPending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.FrameReady) begin
            bus.FrameNext <= 1'b1;
            bus.Busy      <= 1'b1;
            if (needSync) begin
              state         <= SYNC;
              byteCnt       <= SYNC_CNT;
              syncCountdown <= SYNC_RELOAD;
              syncPending   <= 1'b0;
            end else begin
              state   <= FRAME;
              byteCnt <= FRAME_CNT;
              if (syncCountdown != 8'd0) begin
                syncCountdown <= syncCountdown - 8'd1;
              end
            end
          end
        end

        SYNC: begin
          if (bus.DataNext) begin
            bus.DataReady <= 1'b1;
            if (byteCnt == CNT_ONE) begin
              bus.DataVal <= 8'h7F;
              state       <= FRAME;
              byteCnt     <= FRAME_CNT;
            end else begin
              bus.DataVal <= 8'hFF;
              byteCnt     <= byteCnt - CNT_ONE;
            end
          end
        end

        FRAME: begin
          if (bus.DataNext) begin
            bus.DataReady <= 1'b1;
            bus.DataVal   <= nextByte;
            byteCnt       <= byteCnt - CNT_ONE;
            if (byteCnt == CNT_ONE) begin
              state    <= IDLE;
              bus.Busy <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pack_to_serial_gen.sv
// Scoreboard bench for pack_to_serial_gen. The driver issues frames and byte
// requests; the monitor predicts each accepted frame's byte stream from the
// sync rules and compares every output cycle.
module tb_pack_to_serial_gen;

  localparam int FB      = 16;
  localparam int SI      = 15;
  localparam int SB      = 4;
  localparam bit SEN     = 1'b1;
  localparam bit LSB     = 1'b1;
  localparam int FRAME_W = 8 * FB;

  logic clk;
  logic rst;

  pack_to_serial_gen_if #(.FRAME_BYTES(FB)) bus ();
  pack_to_serial_gen_if #(.FRAME_BYTES(3))  bus2 ();

  pack_to_serial_gen #(
    .FRAME_BYTES(FB), .SYNC_INTERVAL(SI), .SYNC_BYTES(SB),
    .SYNC_ENABLE(SEN), .LSB_FIRST(LSB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  pack_to_serial_gen #(
    .FRAME_BYTES(3), .SYNC_INTERVAL(15), .SYNC_BYTES(1),
    .SYNC_ENABLE(1'b1), .LSB_FIRST(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state.
  logic [7:0]         expQ[$];
  int                 obsCounts[$];
  logic [FRAME_W-1:0] curFrame;
  bit                 firstAfterReset = 1'b1;
  bit                 pending = 1'b0;
  int                 unsynced = 0;
  int                 accepted = 0;
  int                 frameStrobes = 0;
  int                 frameNextSeen = 0;
  logic [7:0]         lastVal = 8'h00;

  // Byte stream the spec prescribes for one frame.
  function automatic void pushFrame(input logic [FRAME_W-1:0] f, input bit withSync);
    if (withSync) begin
      for (int i = 0; i < SB - 1; i++) expQ.push_back(8'hFF);
      expQ.push_back(8'h7F);
    end
    for (int i = 0; i < FB; i++)
      expQ.push_back(LSB ? f[8*i +: 8] : f[8*(FB-1-i) +: 8]);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  bit         busyBefore;
  bit         syncNow;
  logic [7:0] expByte;
  always begin
    @(posedge clk);
    #1;
    if (bus.FrameNext === 1'b1) frameNextSeen++;
    if (!rst) begin
      check("rstDataReady", bus.DataReady, 1'b0);
      check("rstFrameNext", bus.FrameNext, 1'b0);
      check("rstDataVal",   bus.DataVal,   8'h00);
      check("rstBusy",      bus.Busy,      1'b0);
      expQ.delete();
      firstAfterReset = 1'b1;
      pending         = 1'b0;
      unsynced        = 0;
      frameStrobes    = 0;
      lastVal         = 8'h00;
    end else begin
      busyBefore = (expQ.size() != 0);
      check("frameNext", bus.FrameNext, bus.FrameReady && !busyBefore);
      check("dataReady", bus.DataReady, bus.DataNext && busyBefore);
      if (bus.DataReady === 1'b1 && expQ.size() != 0) begin
        expByte = expQ.pop_front();
        check("dataVal", bus.DataVal, expByte);
        lastVal = expByte;
        frameStrobes++;
        if (expQ.size() == 0) obsCounts.push_back(frameStrobes);
      end else if (bus.DataReady !== 1'b1) begin
        check("dataHold", bus.DataVal, lastVal);
      end
      if (bus.FrameReady && !busyBefore) begin
        syncNow = SEN && (firstAfterReset || pending || unsynced >= SI);
        pushFrame(curFrame, syncNow);
        firstAfterReset = 1'b0;
        unsynced        = syncNow ? 0 : unsynced + 1;
        frameStrobes    = 0;
        accepted++;
        if (syncNow) pending = 1'b0;
        else if (bus.ForceSync) pending = 1'b1;
      end else if (bus.ForceSync) begin
        pending = 1'b1;
      end
      check("busy", bus.Busy, expQ.size() != 0);
    end
  end

  task automatic setFrame(input logic [FRAME_W-1:0] f);
    curFrame  = f;
    bus.Frame = f;
  endtask

  function automatic logic [FRAME_W-1:0] randFrame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // dnMode 0: DataNext held high; 1: repeating 1,0,0,1; 2: random.
  // forceFrame > 0: one ForceSync pulse partway through that frame;
  // forceFrame < 0: random ForceSync pulses.
  task automatic runFrames(input int n, input int dnMode, input int forceFrame,
                           input logic [FRAME_W-1:0] fixedFrame, input bit useFixed);
    int acc0, cyc, forceWait;
    bit forced;
    acc0 = accepted; cyc = 0; forceWait = 0; forced = 1'b0;
    setFrame(useFixed ? fixedFrame : randFrame());
    bus.FrameReady = 1'b1;
    while ((accepted - acc0 < n || expQ.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (accepted - acc0 >= n) bus.FrameReady = 1'b0;
      if (!useFixed) setFrame(randFrame());
      case (dnMode)
        0:       bus.DataNext = 1'b1;
        1:       bus.DataNext = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.DataNext = ($urandom_range(0, 3) != 0);
      endcase
      bus.ForceSync = 1'b0;
      if (forceFrame > 0 && !forced && accepted - acc0 == forceFrame) begin
        forceWait++;
        if (forceWait == 6) begin
          bus.ForceSync = 1'b1;
          forced = 1'b1;
        end
      end else if (forceFrame < 0 && $urandom_range(0, 49) == 0) begin
        bus.ForceSync = 1'b1;
      end
    end
    check("runInBudget", cyc < 4000, 1'b1);
    bus.FrameReady = 1'b0;
    bus.DataNext   = 1'b0;
    bus.ForceSync  = 1'b0;
  endtask

  logic [7:0] got2[$];
  logic [7:0] exp2[4];
  int         fn2;
  int         fnBase;
  int         acc0;
  int         cyc;

  initial begin
    rst = 1'b0;
    bus.FrameReady = 1'b0; bus.DataNext = 1'b0; bus.ForceSync = 1'b0;
    setFrame('0);
    bus2.Frame = 24'h0; bus2.FrameReady = 1'b0; bus2.DataNext = 1'b0; bus2.ForceSync = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single synced frame with ascending bytes.
    obsCounts.delete();
    fnBase = frameNextSeen;
    runFrames(1, 0, 0, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
    check("t1FrameNextPulses", frameNextSeen - fnBase, 1);
    check("t1Frames", obsCounts.size(), 1);
    if (obsCounts.size() == 1) check("t1Strobes", obsCounts[0], SB + FB);

    // 17 back-to-back frames: sync on the 1st and 17th only.
    doReset();
    obsCounts.delete();
    runFrames(17, 0, 0, '0, 1'b0);
    check("t2Frames", obsCounts.size(), 17);
    for (int i = 0; i < obsCounts.size() && i < 17; i++)
      check($sformatf("t2Strobes[%0d]", i), obsCounts[i],
            (i == 0 || i == 16) ? SB + FB : FB);

    // ForceSync partway through frame 3 syncs frame 4 only.
    doReset();
    obsCounts.delete();
    runFrames(5, 0, 3, '0, 1'b0);
    check("t3Frames", obsCounts.size(), 5);
    for (int i = 0; i < obsCounts.size() && i < 5; i++)
      check($sformatf("t3Strobes[%0d]", i), obsCounts[i],
            (i == 0 || i == 3) ? SB + FB : FB);

    // DataNext toggling 1,0,0,1.
    obsCounts.delete();
    runFrames(2, 1, 0, '0, 1'b0);
    check("t4Frames", obsCounts.size(), 2);

    // Reset after 5 frame bytes; nothing residual, next frame synced.
    doReset();
    obsCounts.delete();
    acc0 = accepted;
    setFrame(randFrame());
    bus.FrameReady = 1'b1;
    bus.DataNext   = 1'b1;
    cyc = 0;
    while (frameStrobes < SB + 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (accepted != acc0) bus.FrameReady = 1'b0;
    end
    check("t5ReachedByte5", cyc < 200, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus.DataNext = 1'b0;
    check("t5NoCompletedFrame", obsCounts.size(), 0);
    runFrames(1, 0, 0, '0, 1'b0);
    check("t5Frames", obsCounts.size(), 1);
    if (obsCounts.size() == 1) check("t5Strobes", obsCounts[0], SB + FB);

    // Randomised frames, stalls and forced syncs.
    doReset();
    obsCounts.delete();
    runFrames(40, 2, -1, '0, 1'b0);
    check("rndFrames", obsCounts.size(), 40);

    // Second configuration: 3-byte frame, MSB first, 1-byte sync.
    exp2 = '{8'h7F, 8'hAA, 8'hBB, 8'hCC};
    fn2 = 0;
    @(negedge clk);
    bus2.Frame      = 24'hAABBCC;
    bus2.FrameReady = 1'b1;
    bus2.DataNext   = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus2.FrameNext) fn2++;
      if (bus2.DataReady) got2.push_back(bus2.DataVal);
      @(negedge clk);
      if (fn2 != 0) bus2.FrameReady = 1'b0;
    end
    check("cfg2FrameNext", fn2, 1);
    check("cfg2Strobes", got2.size(), 4);
    for (int i = 0; i < got2.size() && i < 4; i++)
      check($sformatf("cfg2Byte[%0d]", i), got2[i], exp2[i]);

    check("scoreboardEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pack_to_serial_gen.md
# pack_to_serial_gen

Parametrised frame-to-byte serialiser for the trace output path. It takes whole frames of FRAME_BYTES bytes from the packet buffer and emits them one byte per request to the serial (or other) byte sink. Every SYNC_INTERVAL+1 frames, on the first frame after reset, and on demand, it inserts a sync sequence of (SYNC_BYTES-1)×0xFF followed by 0x7F. Compared with the fixed 16-byte generation, this block adds configurable frame and sync lengths, selectable byte order, forced sync and a busy flag, and has no idle cycle at the sync-to-frame or frame-to-idle transitions.

## Interface
Parameters:
- FRAME_BYTES, 16: bytes per frame. Range 1..64.
- SYNC_INTERVAL, 15: frames sent without sync between syncs. Range 0..255. 0 means sync before every frame.
- SYNC_BYTES, 4: sync sequence length. Range 1..16.
- SYNC_ENABLE, 1: 0 means sync is never emitted and ForceSync is ignored.
- LSB_FIRST, 1: 1 sends Frame[7:0] first. 0 sends the top byte first.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- Frame, in, 8*FRAME_BYTES: frame data. Valid while FrameReady is high.
- FrameReady, in, 1: a frame is available.
- FrameNext, out, 1: one-cycle strobe that acknowledges and consumes the frame.
- ForceSync, in, 1: requests a sync before the next frame. Level or pulse.
- DataNext, in, 1: the sink requests the next byte.
- DataVal, out, 8: output byte.
- DataReady, out, 1: one-cycle strobe meaning DataVal is valid.
- Busy, out, 1: high while in SYNC or FRAME.

## Operation
- States (one-hot):
  - IDLE: waiting for a frame.
  - SYNC: emitting the sync sequence.
  - FRAME: emitting frame bytes.
- Registers:
  - shift register, 8*FRAME_BYTES bits.
  - byte counter, $clog2(max(FRAME_BYTES,SYNC_BYTES)+1) bits.
  - sync countdown, 8 bits.
  - syncPending flag.
- Reset (rst=0 at a clock edge):
  - state IDLE.
  - DataReady, FrameNext, DataVal and Busy all 0.
  - sync countdown 0 and syncPending 0, so the first frame after reset is preceded by sync.
  - Any frame in progress is abandoned.
- syncPending:
  - Set by ForceSync=1 on any edge.
  - Cleared on the edge that enters SYNC.
  - If ForceSync=1 on that same edge, the request is consumed (clear wins).
- IDLE with FrameReady=1, on the edge:
  - FrameNext=1 for one cycle and Frame is latched.
  - If SYNC_ENABLE and (countdown==0 or syncPending): go to SYNC, counter=SYNC_BYTES, countdown=SYNC_INTERVAL.
  - Otherwise: go to FRAME, counter=FRAME_BYTES, countdown decrements (saturating at 0).
- SYNC, on each edge with DataNext=1:
  - DataReady=1.
  - DataVal=0x7F if counter==1, else 0xFF.
  - counter decrements.
  - When counter==1, go directly to FRAME with counter=FRAME_BYTES.
- FRAME, on each edge with DataNext=1:
  - DataReady=1.
  - DataVal is the next byte: low byte if LSB_FIRST, else high byte.
  - The register shifts by 8, zero-filled.
  - counter decrements.
  - When counter==1, go to IDLE.
- DataNext=0 stalls in place with no output. DataNext is ignored in IDLE.
- DataVal holds its last value when DataReady=0.

## Timing
- Frame acceptance: FrameReady high at edge N gives FrameNext high in cycle N+1 (exactly one cycle). Busy rises in the same cycle.
- Byte latency: DataNext high at edge M gives DataReady/DataVal valid in cycle M+1. Maximum throughput is one byte per clock.
- Byte count: a frame with sync gives exactly SYNC_BYTES+FRAME_BYTES strobes. A frame without sync gives exactly FRAME_BYTES strobes. There are no dead DataNext cycles.
- Back-to-back frames:
  - The last byte strobe and the return to IDLE happen on the same edge.
  - The next FrameNext is no earlier than 1 cycle after the last DataReady.
  - Minimum period is FRAME_BYTES+1 cycles per unsynced frame with DataNext held high.
- FrameReady is not sampled outside IDLE.
- Frame changing while FrameReady=1 in IDLE: the value at the accepting edge is the one latched.

## Test plan
- Reset, then FrameReady=1 with Frame=0x0F0E..0100, and DataNext held high (defaults):
  - FrameNext pulses once.
  - Output is FF FF FF 7F 00 01 .. 0F (20 strobes, back-to-back).
  - Busy falls with the last strobe.
- 17 consecutive frames (defaults):
  - Frame 1 is synced.
  - Frames 2–16 carry no sync.
  - Frame 17 is synced.
  - A sync count per frame of 1,0×15,1 passes.
- ForceSync pulse mid-frame 3 with SYNC_INTERVAL=15: frame 4 is preceded by FF FF FF 7F, and frame 5 is not.
- DataNext toggling 1,0,0,1 during FRAME:
  - Strobes appear only in the cycle after each sampled 1.
  - Byte order and count are preserved.
  - DataVal holds between strobes.
- rst=0 for one cycle after 5 frame bytes:
  - Outputs return to 0 next cycle.
  - The next frame starts with sync.
  - No residual bytes are emitted.
- FRAME_BYTES=3, LSB_FIRST=0, SYNC_BYTES=1, Frame=0xAABBCC: output 7F AA BB CC.
